regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the write-back data width.
REQ-002 The block SHALL have port CLK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit, the reset, synchronous and active-high.
REQ-004 The block SHALL have port alu_valid, input, 1 bit, ALU write-back request.
REQ-005 The block SHALL have port alu_rd, input, 5 bits, ALU destination register.
REQ-006 The block SHALL have port alu_data, input, XLEN bits, ALU result.
REQ-007 The block SHALL have port alu_ready, output, 1 bit, ALU request accepted this cycle.
REQ-008 The block SHALL have ports mem_valid, mem_rd, mem_data and mem_ready with the same widths and meanings for the load unit.
REQ-009 The block SHALL have port issue_valid, input, 1 bit, instruction issued with a destination.
REQ-010 The block SHALL have port issue_rd, input, 5 bits, destination of the issued instruction.
REQ-011 The block SHALL have port RegWrite, output, 1 bit, register-bank write enable.
REQ-012 The block SHALL have port writeReg, output, 5 bits, register-bank write address.
REQ-013 The block SHALL have port writeData, output, XLEN bits, register-bank write data.
REQ-014 The block SHALL have port pending, output, 32 bits, scoreboard; bit i = 1 means x[i] awaits write-back.

Function
REQ-015 A requester SHALL be accepted (ready=1) in the same cycle its valid is 1 and it holds the grant; ready SHALL be combinational from valid and arbiter state.
REQ-016 At most one requester SHALL be accepted per cycle; the loser SHALL see ready=0 and keep valid, rd and data stable until accepted.
REQ-017 The accepted rd/data SHALL appear on writeReg/writeData with RegWrite=1 exactly one cycle after acceptance (registered outputs, latency 1).
REQ-018 An accepted request with rd=0 SHALL produce RegWrite=0 in the following cycle (consumed, never written).
REQ-019 With no acceptance, RegWrite SHALL be 0 in the following cycle; writeReg/writeData SHALL hold their last values.
REQ-020 Arbiter state SHALL be a 1-bit last_grant (0=ALU, 1=MEM), updated only on a cycle where both request.
REQ-021 issue_valid with issue_rd≠0 SHALL set pending[issue_rd] at the next edge.
REQ-022 Each cycle RegWrite=1, pending[writeReg] SHALL clear at that edge.
REQ-023 If the same register is set and cleared in one cycle, set SHALL win.
REQ-024 pending[0] SHALL always be 0.
REQ-025 A single requester SHALL always be accepted, whatever last_grant holds.

Reset
REQ-026 While RST=1 at an edge: RegWrite=0, writeReg=0, writeData=0, pending=0, last_grant=0.
REQ-027 A request presented in a cycle with RST=1 SHALL NOT be accepted (both ready=0) and SHALL NOT produce a write.
REQ-028 A write registered in the cycle before RST SHALL be cancelled (RegWrite=0 after reset edge).

Configuration
REQ-029 With macro WB_RR_ARB_EN defined, both-valid conflicts SHALL grant the requester not in last_grant (round-robin).
REQ-030 Without WB_RR_ARB_EN, both-valid conflicts SHALL always grant MEM (fixed priority); last_grant SHALL be unused and tied to 0.

Structure
REQ-031 A shared package regfile_pkg SHALL hold NUM_REGS=32, REG_AW=5 and the enum wb_src_t {WB_ALU, WB_MEM}.
REQ-032 The scoreboard SHALL be a sub-module wb_scoreboard (inputs set_en/set_idx, clr_en/clr_idx; output pending).

Verification
REQ-033 Reset: RST=1 two cycles, alu_valid=1 rd=5 -> alu_ready=0, RegWrite=0, pending=0.
REQ-034 Single write: alu_valid=1 rd=3 data=32'hDEADBEEF -> alu_ready=1 same cycle; next cycle RegWrite=1, writeReg=3, writeData=32'hDEADBEEF.
REQ-035 Conflict, both valid 3 cycles (alu rd=1, mem rd=2) with WB_RR_ARB_EN -> grants MEM, ALU, MEM; without it -> MEM, MEM, MEM.
REQ-036 x0: mem_valid=1 rd=0 data=7 -> mem_ready=1; next cycle RegWrite=0; pending[0]=0.
REQ-037 Scoreboard: issue rd=9; later ALU writes rd=9 while issue rd=9 is asserted the same cycle -> pending[9] stays 1.
REQ-038 Reset mid-operation: accept alu rd=4, assert RST next cycle -> RegWrite=0, pending=0 after that edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file write-back path.
//   NUM_REGS  : number of architectural registers (x0..x31)
//   REG_AW    : register address width
//   wb_src_t  : write-back source identifier, also used as the arbiter's
//               last-grant state
//   reg_mask  : one-hot decode of a register index
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_t;

  function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_AW-1:0] idx);
    logic [NUM_REGS-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// -----------------------------------------------------------------------------
// wb_scoreboard
// Pending-write scoreboard: one bit per architectural register, set when an
// instruction with that destination issues and cleared when its result is
// written back. A set and a clear of the same register in one cycle leaves the
// bit set (the newer producer is still outstanding). Bit 0 is hard-wired low.
//
// Ports
//   CLK      in   clock, rising edge
//   RST      in   synchronous active-high reset
//   set_en   in   mark set_idx as pending
//   set_idx  in   register being issued
//   clr_en   in   clear clr_idx (write-back happening this cycle)
//   clr_idx  in   register being written back
//   pending  out  scoreboard vector, bit i = x[i] awaits write-back
// -----------------------------------------------------------------------------
module wb_scoreboard
  import regfile_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic                set_en,
  input  logic [REG_AW-1:0]   set_idx,
  input  logic                clr_en,
  input  logic [REG_AW-1:0]   clr_idx,
  output logic [NUM_REGS-1:0] pending
);

  logic [NUM_REGS-1:0] pending_nxt;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    pending_nxt = pending;
    if (clr_en) pending_nxt = pending_nxt & ~reg_mask(clr_idx);
    // Applied after the clear so a same-cycle set wins.
    if (set_en) pending_nxt = pending_nxt | reg_mask(set_idx);
    pending_nxt[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge CLK) begin
    if (RST) pending <= '0;
    else     pending <= pending_nxt;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Arbitrates the ALU and load-unit write-back requests onto the single
// register-bank write port and tracks outstanding destinations.
//
// Arbitration: a lone requester is always accepted. On a conflict the load
// unit wins (fixed priority) unless WB_RR_ARB_EN is defined, in which case the
// requester not recorded in last_grant wins (round-robin). Nothing is accepted
// while RST is high. The accepted request reaches the write port one cycle
// later; rd=0 is consumed without asserting RegWrite.
//
// Configuration macro: WB_RR_ARB_EN (round-robin conflict arbitration)
//
// Ports
//   CLK          in   clock, rising edge
//   RST          in   synchronous active-high reset
//   alu_valid    in   ALU write-back request
//   alu_rd       in   ALU destination register
//   alu_data     in   ALU result
//   alu_ready    out  ALU request accepted this cycle (combinational)
//   mem_valid    in   load-unit write-back request
//   mem_rd       in   load-unit destination register
//   mem_data     in   load-unit result
//   mem_ready    out  load-unit request accepted this cycle (combinational)
//   issue_valid  in   instruction issued with a destination
//   issue_rd     in   destination of the issued instruction
//   RegWrite     out  register-bank write enable (registered)
//   writeReg     out  register-bank write address (registered)
//   writeData    out  register-bank write data (registered)
//   pending      out  scoreboard, bit i = x[i] awaits write-back
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                alu_valid,
  input  logic [REG_AW-1:0]   alu_rd,
  input  logic [XLEN-1:0]     alu_data,
  output logic                alu_ready,
  input  logic                mem_valid,
  input  logic [REG_AW-1:0]   mem_rd,
  input  logic [XLEN-1:0]     mem_data,
  output logic                mem_ready,
  input  logic                issue_valid,
  input  logic [REG_AW-1:0]   issue_rd,
  output logic                RegWrite,
  output logic [REG_AW-1:0]   writeReg,
  output logic [XLEN-1:0]     writeData,
  output logic [NUM_REGS-1:0] pending
);

  wb_src_t             last_grant;
  logic                grant_mem;
  logic                acc;
  logic [REG_AW-1:0]   acc_rd;
  logic [XLEN-1:0]     acc_data;

  // With last_grant held at WB_ALU (fixed-priority build) this reduces to
  // grant_mem = mem_valid.
  always_comb begin
    grant_mem = mem_valid & (~alu_valid | (last_grant == WB_ALU));
    alu_ready = alu_valid & ~grant_mem & ~RST;
    mem_ready = grant_mem & ~RST;
  end

`ifdef WB_RR_ARB_EN
  // Only a genuine conflict moves the round-robin pointer.
  always_ff @(posedge CLK) begin
    if (RST)                          last_grant <= WB_ALU;
    else if (alu_valid && mem_valid)  last_grant <= grant_mem ? WB_MEM : WB_ALU;
  end
`else
  assign last_grant = WB_ALU;
`endif

  always_comb begin
    acc      = 1'b0;
    acc_rd   = '0;
    acc_data = '0;
    if (alu_ready) begin
      acc      = 1'b1;
      acc_rd   = alu_rd;
      acc_data = alu_data;
    end else if (mem_ready) begin
      acc      = 1'b1;
      acc_rd   = mem_rd;
      acc_data = mem_data;
    end
  end

  // Address/data only move on acceptance; RegWrite pulses for one cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RegWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
    end else begin
      RegWrite <= acc && (acc_rd != '0);
      if (acc) begin
        writeReg  <= acc_rd;
        writeData <= acc_data;
      end
    end
  end

  wb_scoreboard u_scoreboard (
    .CLK     (CLK),
    .RST     (RST),
    .set_en  (issue_valid && (issue_rd != '0)),
    .set_idx (issue_rd),
    .clr_en  (RegWrite),
    .clr_idx (writeReg),
    .pending (pending)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Self-checking bench for regfile_wb_arbiter. A behavioural model predicts the
// ready signals and the registered write-port/scoreboard state for every cycle;
// predictions are queued when stimulus is applied and popped when the DUT
// registers its outputs. Scenario tasks add fixed expectations on top.
// Define WB_RR_ARB_EN for both the bench and the design to check round-robin.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  localparam int XLEN = 32;

`ifdef WB_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            RST;
  logic            alu_valid, mem_valid, issue_valid;
  logic [4:0]      alu_rd, mem_rd, issue_rd;
  logic [XLEN-1:0] alu_data, mem_data;
  logic            alu_ready, mem_ready;
  logic            RegWrite;
  logic [4:0]      writeReg;
  logic [XLEN-1:0] writeData;
  logic [31:0]     pending;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        rst;
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [31:0] pend;
  } exp_t;

  exp_t exp_q[$];

  // Model state
  logic        m_rw   = 1'b0;
  logic [4:0]  m_wr   = '0;
  logic [31:0] m_wd   = '0;
  logic [31:0] m_pend = '0;
  logic        m_lg   = 1'b0;

  // Ready values observed / predicted in the most recent step
  logic obs_ar, obs_mr, exp_ar, exp_mr;

  regfile_wb_arbiter #(.XLEN(XLEN)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .RegWrite    (RegWrite),
    .writeReg    (writeReg),
    .writeData   (writeData),
    .pending     (pending)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] bmask(input logic [4:0] i);
    return 32'h1 << i;
  endfunction

  task automatic idle_inputs();
    RST = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
  endtask

  // One clock cycle with the currently driven inputs.
  task automatic step();
    logic gm;
    exp_t e, got;
    @(negedge CLK);
    gm     = mem_valid && (!alu_valid || !RR || !m_lg);
    exp_mr = !RST && gm;
    exp_ar = !RST && alu_valid && !gm;
    obs_ar = alu_ready;
    obs_mr = mem_ready;
    total++;
    if (alu_ready !== exp_ar) begin
      bad++;
      $display("FAIL alu_ready t=%0t got=%b want=%b", $time, alu_ready, exp_ar);
    end
    total++;
    if (mem_ready !== exp_mr) begin
      bad++;
      $display("FAIL mem_ready t=%0t got=%b want=%b", $time, mem_ready, exp_mr);
    end
    if (RST) begin
      m_rw = 1'b0; m_wr = '0; m_wd = '0; m_pend = '0; m_lg = 1'b0;
    end else begin
      if (m_rw) m_pend = m_pend & ~bmask(m_wr);
      if (issue_valid && issue_rd != 5'd0) m_pend = m_pend | bmask(issue_rd);
      m_pend[0] = 1'b0;
      if (exp_ar) begin
        m_rw = (alu_rd != 5'd0); m_wr = alu_rd; m_wd = alu_data;
      end else if (exp_mr) begin
        m_rw = (mem_rd != 5'd0); m_wr = mem_rd; m_wd = mem_data;
      end else begin
        m_rw = 1'b0;
      end
      if (RR && alu_valid && mem_valid) m_lg = gm;
    end
    e.rst = RST; e.rw = m_rw; e.wr = m_wr; e.wd = m_wd; e.pend = m_pend;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    got = exp_q.pop_front();
    total++;
    if (RegWrite !== got.rw) begin
      bad++;
      $display("FAIL RegWrite t=%0t got=%b want=%b", $time, RegWrite, got.rw);
    end
    if (got.rw || got.rst) begin
      total++;
      if (writeReg !== got.wr || writeData !== got.wd) begin
        bad++;
        $display("FAIL write_port t=%0t got=%0d/%h want=%0d/%h",
                 $time, writeReg, writeData, got.wr, got.wd);
      end
    end
    total++;
    if (pending !== got.pend) begin
      bad++;
      $display("FAIL pending t=%0t got=%h want=%h", $time, pending, got.pend);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1'b1; alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h55;
    issue_valid = 1'b1; issue_rd = 5'd5;
    repeat (2) begin
      step();
      total++;
      if (obs_ar !== 1'b0 || RegWrite !== 1'b0 || pending !== 32'h0) begin
        bad++;
        $display("FAIL reset ready/RegWrite/pending got=%b/%b/%h want=0/0/0",
                 obs_ar, RegWrite, pending);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_single_write();
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF;
    step();
    total++;
    if (obs_ar !== 1'b1) begin
      bad++; $display("FAIL single_ready got=%b want=1", obs_ar);
    end
    idle_inputs();
    step();
    // Outputs here reflect the idle cycle; check the held address/data.
    total++;
    if (writeReg !== 5'd3 || writeData !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL single_hold got=%0d/%h want=3/deadbeef", writeReg, writeData);
    end
  endtask

  task automatic test_conflict();
    logic [2:0] want_mem;
    want_mem = RR ? 3'b101 : 3'b111;  // bit0 = first cycle
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'hB2;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (obs_mr !== want_mem[i] || obs_ar !== !want_mem[i]) begin
        bad++;
        $display("FAIL conflict_grant%0d got mem/alu=%b/%b want=%b/%b",
                 i, obs_mr, obs_ar, want_mem[i], !want_mem[i]);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_x0();
    idle_inputs();
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'd7;
    step();
    total++;
    if (obs_mr !== 1'b1) begin
      bad++; $display("FAIL x0_ready got=%b want=1", obs_mr);
    end
    idle_inputs();
    step();
    total++;
    if (RegWrite !== 1'b0 || pending[0] !== 1'b0) begin
      bad++;
      $display("FAIL x0_write got RegWrite=%b pending0=%b want=0/0", RegWrite, pending[0]);
    end
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    total++;
    if (pending[9] !== 1'b1) begin
      bad++; $display("FAIL sb_set got=%b want=1", pending[9]);
    end
    idle_inputs();
    issue_valid = 1'b1; issue_rd = 5'd12;
    step();
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    step();
    // RegWrite for x9 is high in this cycle; re-issue x9 at the same time.
    idle_inputs();
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    total++;
    if (pending[9] !== 1'b1) begin
      bad++; $display("FAIL sb_set_wins got=%b want=1", pending[9]);
    end
    idle_inputs();
    mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'hC;
    step();
    idle_inputs();
    step();
    total++;
    if (pending[12] !== 1'b0 || pending[9] !== 1'b1) begin
      bad++;
      $display("FAIL sb_clear got p12=%b p9=%b want=0/1", pending[12], pending[9]);
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    issue_valid = 1'b1; issue_rd = 5'd4;
    step();
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
    step();
    idle_inputs();
    RST = 1'b1;
    step();
    total++;
    if (RegWrite !== 1'b0 || pending !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid got RegWrite=%b pending=%h want=0/0", RegWrite, pending);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    for (int i = 0; i < 60; i++) begin
      if (!alu_valid || exp_ar) begin
        alu_valid = ($urandom_range(0, 3) != 0);
        alu_rd    = 5'($urandom_range(0, 31));
        alu_data  = $urandom;
      end
      if (!mem_valid || exp_mr) begin
        mem_valid = ($urandom_range(0, 2) != 0);
        mem_rd    = 5'($urandom_range(0, 31));
        mem_data  = $urandom;
      end
      issue_valid = $urandom_range(0, 1) == 1;
      issue_rd    = 5'($urandom_range(0, 31));
      step();
    end
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    exp_ar = 1'b0;
    exp_mr = 1'b0;
    test_reset();
    test_single_write();
    test_conflict();
    test_x0();
    test_scoreboard();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
